// File: rtl/zoom_uart_pkg.sv
// Shared UART definitions: assembler state encoding, word payload, default divisor.
package zoom_uart_pkg;

    // Default baud divisor, shared with uart_rx.
    localparam logic [12:0] UART_DIVISOR_DEFAULT = 13'h1869;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 16;

    // Byte-pair assembler states.
    typedef enum logic {
        LO_WAIT = 1'b0,
        HI_WAIT = 1'b1
    } asm_state_e;

    // Little-endian word assembled from two received bytes.
    typedef struct packed {
        logic [BYTE_W-1:0] hi;
        logic [BYTE_W-1:0] lo;
    } word_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word fall-through FIFO with level, full and empty.
module sync_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push_c;
    logic             do_pop_c;

    // Pop only when non-empty; push when space exists or a pop frees a slot this cycle.
    always_comb begin
        do_pop_c  = pop && (count != '0);
        do_push_c = push && ((count != LW'(DEPTH)) || do_pop_c);
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push_c, do_pop_c})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents beyond the occupied range are don't-care.
    always_ff @(posedge clk) begin
        if (do_push_c && !clear) begin
            mem[wr_ptr] <= wdata;
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign level = count;

endmodule

// File: rtl/uart_rx_word_fifo.sv
// Pairs UART byte strobes into little-endian words, buffers them, and flags overrun/timeout.
module uart_rx_word_fifo
    import zoom_uart_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65000,
    parameter int unsigned TW             = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     byte_valid,
    input  logic [BYTE_W-1:0]        byte_in,
    input  logic                     flush,
    input  logic                     err_clear,
    output logic                     word_valid,
    output logic [WORD_W-1:0]        word_out,
    input  logic                     word_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     partial,
    output logic                     overrun,
    output logic                     timeout_err
);

    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic          TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);

    asm_state_e        state;
    logic [BYTE_W-1:0] lo_reg;
    logic [TW-1:0]     timer;

    word_t             push_word_c;
    logic              push_c;
    logic              pop_c;
    logic              timeout_c;
    logic              overrun_evt_c;

    logic [WORD_W-1:0] fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;

    // Handshake decode and error events for this cycle; flush suppresses all of them.
    always_comb begin
        push_word_c    = '0;
        push_word_c.hi = byte_in;
        push_word_c.lo = lo_reg;
        pop_c          = !fifo_empty && word_ready && !flush;
        push_c         = (state == HI_WAIT) && byte_valid && !flush;
        timeout_c      = TIMEOUT_EN && (state == HI_WAIT) && !byte_valid && !flush
                         && (timer == TIMEOUT_LAST);
        overrun_evt_c  = push_c && fifo_full && !pop_c;
    end

    // Byte-pair assembler with inter-byte timeout; an arriving byte beats the timeout.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            state  <= LO_WAIT;
            lo_reg <= '0;
            timer  <= '0;
        end else begin
            case (state)
                LO_WAIT: begin
                    if (byte_valid) begin
                        lo_reg <= byte_in;
                        timer  <= '0;
                        state  <= HI_WAIT;
                    end
                end
                HI_WAIT: begin
                    if (byte_valid) begin
                        state <= LO_WAIT;
                    end else if (timeout_c) begin
                        timer <= '0;
                        state <= LO_WAIT;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
            endcase
        end
    end

    // Sticky error flags; a new event in the same cycle as err_clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            overrun     <= (overrun && !err_clear) || overrun_evt_c;
            timeout_err <= (timeout_err && !err_clear) || timeout_c;
        end
    end

    sync_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (push_c),
        .wdata (push_word_c),
        .pop   (pop_c),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    assign word_valid = !fifo_empty;
    assign word_out   = fifo_empty ? '0 : fifo_rdata;
    assign partial    = (state == HI_WAIT);

endmodule

// File: tb/tb_uart_rx_word_fifo.sv
// Randomized and directed bench for uart_rx_word_fifo against a queue-based model.
module tb_uart_rx_word_fifo;

    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        byte_valid;
    logic [7:0]  byte_in;
    logic        flush;
    logic        err_clear;
    logic        word_valid;
    logic [15:0] word_out;
    logic        word_ready;
    logic [2:0]  level;
    logic        partial;
    logic        overrun;
    logic        timeout_err;

    int n_checks = 0;
    int n_pass   = 0;

    uart_rx_word_fifo #(
        .DEPTH          (DEPTH),
        .TIMEOUT_CYCLES (TIMEOUT),
        .TW             (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .byte_valid  (byte_valid),
        .byte_in     (byte_in),
        .flush       (flush),
        .err_clear   (err_clear),
        .word_valid  (word_valid),
        .word_out    (word_out),
        .word_ready  (word_ready),
        .level       (level),
        .partial     (partial),
        .overrun     (overrun),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    endtask

    // Behavioural model: a word queue, a held low byte, and an idle-cycle count.
    logic [15:0] q[$];
    bit          m_partial;
    logic [7:0]  m_lo;
    int          m_idle;
    bit          m_ov;
    bit          m_to;
    bit          model_ready = 0;

    always @(posedge clk) begin
        bit ev_ov, ev_to;
        ev_ov = 0;
        ev_to = 0;
        if (reset) begin
            q.delete();
            m_partial = 0;
            m_idle = 0;
            m_ov = 0;
            m_to = 0;
            model_ready = 1;
        end else if (flush) begin
            q.delete();
            m_partial = 0;
            m_idle = 0;
            if (err_clear) begin
                m_ov = 0;
                m_to = 0;
            end
        end else begin
            if (word_ready && q.size() > 0) void'(q.pop_front());
            if (byte_valid) begin
                if (m_partial) begin
                    m_partial = 0;
                    if (q.size() < DEPTH) q.push_back({byte_in, m_lo});
                    else ev_ov = 1;
                end else begin
                    m_partial = 1;
                    m_lo = byte_in;
                    m_idle = 0;
                end
            end else if (m_partial) begin
                m_idle++;
                if (TIMEOUT != 0 && m_idle == TIMEOUT) begin
                    m_partial = 0;
                    ev_to = 1;
                end
            end
            m_ov = (m_ov && !err_clear) || ev_ov;
            m_to = (m_to && !err_clear) || ev_to;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (model_ready) begin
            check("m_word_valid", 32'(word_valid), 32'(q.size() != 0));
            check("m_word_out", 32'(word_out), (q.size() != 0) ? 32'(q[0]) : 32'h0);
            check("m_level", 32'(level), 32'(q.size()));
            check("m_partial", 32'(partial), 32'(m_partial));
            check("m_overrun", 32'(overrun), 32'(m_ov));
            check("m_timeout_err", 32'(timeout_err), 32'(m_to));
        end
    end

    // Apply inputs at a falling edge, then advance to the next falling edge.
    task automatic step(input logic bv, input logic [7:0] b, input logic rdy,
                        input logic fl, input logic clr);
        byte_valid = bv;
        byte_in    = b;
        word_ready = rdy;
        flush      = fl;
        err_clear  = clr;
        @(negedge clk);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 8'h00, rdy, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [15:0] w, input logic rdy);
        step(1'b1, w[7:0], rdy, 1'b0, 1'b0);
        step(1'b1, w[15:8], rdy, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle(1'b0);
        reset = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, 32'(word_valid), 32'h0);
        check({tag, "_word"}, 32'(word_out), 32'h0);
        check({tag, "_level"}, 32'(level), 32'h0);
        check({tag, "_partial"}, 32'(partial), 32'h0);
        check({tag, "_overrun"}, 32'(overrun), 32'h0);
        check({tag, "_timeout"}, 32'(timeout_err), 32'h0);
    endtask

    initial begin
        logic [15:0] w;
        reset = 1'b1;
        byte_valid = 1'b0;
        byte_in = 8'h00;
        flush = 1'b0;
        err_clear = 1'b0;
        word_ready = 1'b0;
        @(negedge clk);
        idle(1'b0);
        reset = 1'b0;
        check_all_zero("reset");

        // Pairing: 34 then 12 gives 1234 one cycle after the high byte.
        step(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
        check("pair_partial", 32'(partial), 32'h1);
        step(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        check("pair_valid", 32'(word_valid), 32'h1);
        check("pair_word", 32'(word_out), 32'h1234);
        check("pair_level", 32'(level), 32'h1);

        // Full FIFO with push and pop together: no overrun, 5th word drains last.
        do_reset();
        for (int i = 0; i < 4; i++) send_word(16'hB000 + 16'(i), 1'b0);
        check("fullpp_level4", 32'(level), 32'h4);
        step(1'b1, 8'h04, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hB0, 1'b1, 1'b0, 1'b0);
        check("fullpp_level", 32'(level), 32'h4);
        check("fullpp_overrun", 32'(overrun), 32'h0);
        for (int i = 1; i <= 4; i++) begin
            check("fullpp_drain", 32'(word_out), 32'hB000 + 32'(i));
            idle(1'b1);
        end
        check("fullpp_empty", 32'(word_valid), 32'h0);

        // Fill then overrun: five words, only the first four survive.
        do_reset();
        for (int i = 0; i < 5; i++) send_word(16'hA000 + 16'(i), 1'b0);
        check("fill_level", 32'(level), 32'h4);
        check("fill_overrun", 32'(overrun), 32'h1);
        for (int i = 0; i < 4; i++) begin
            check("fill_drain", 32'(word_out), 32'hA000 + 32'(i));
            idle(1'b1);
        end
        check("fill_empty", 32'(word_valid), 32'h0);
        check("fill_word_zero", 32'(word_out), 32'h0);

        // Timeout: still partial after 9 idle cycles, dropped on the 10th.
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) idle(1'b0);
        check("to_partial9", 32'(partial), 32'h1);
        check("to_err9", 32'(timeout_err), 32'h0);
        idle(1'b0);
        check("to_partial10", 32'(partial), 32'h0);
        check("to_err10", 32'(timeout_err), 32'h1);
        send_word(16'hABCD, 1'b0);
        check("to_next_word", 32'(word_out), 32'hABCD);

        // Flush with partial=1 and level=2 keeps sticky flags.
        send_word(16'h5678, 1'b0);
        step(1'b1, 8'h9A, 1'b0, 1'b0, 1'b0);
        check("flush_pre_level", 32'(level), 32'h2);
        check("flush_pre_partial", 32'(partial), 32'h1);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check("flush_level", 32'(level), 32'h0);
        check("flush_partial", 32'(partial), 32'h0);
        check("flush_overrun", 32'(overrun), 32'h1);
        check("flush_timeout", 32'(timeout_err), 32'h1);
        do_reset();
        check_all_zero("reset2");

        // A byte arriving on the timeout cycle completes the word.
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) idle(1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        check("race_word", 32'(word_out), 32'h2211);
        check("race_timeout", 32'(timeout_err), 32'h0);

        // err_clear in the same cycle as a timeout leaves the flag set.
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) idle(1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("clr_vs_set", 32'(timeout_err), 32'h1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        check("clr_only", 32'(timeout_err), 32'h0);

        // Wrap-around: 12 words with random ready and gaps.
        do_reset();
        for (int i = 0; i < 12; i++) begin
            w = 16'($urandom);
            step(1'b1, w[7:0], 1'($urandom), 1'b0, 1'b0);
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) idle(1'($urandom));
            step(1'b1, w[15:8], 1'($urandom), 1'b0, 1'b0);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) idle(1'($urandom));
        end
        for (int i = 0; i < 8; i++) idle(1'b1);

        // Free-running random traffic including flushes, clears, long gaps and resets.
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 499) == 0);
            step(($urandom_range(0, 99) < ((i / 200) % 2 == 0 ? 50 : 8)),
                 8'($urandom), 1'($urandom),
                 ($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0));
        end
        reset = 1'b0;
        idle(1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
